// File: rtl/writeback_buffer_pkg.sv
// Shared definitions for the dirty-victim writeback buffer: default widths,
// the derived-width constants, the drain FSM state type and a log2 helper.
package cache_pkg;

    // Ceiling log2, used to size pointers from an entry count.
    function automatic int log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    localparam int WB_DATA_WIDTH   = 32;
    localparam int WB_OFFSET_BITS  = 2;
    localparam int WB_ADDRESS_BITS = 32;
    localparam int WB_DEPTH        = 4;
    localparam int WB_BLOCK_WIDTH  = WB_DATA_WIDTH << WB_OFFSET_BITS;
    localparam int WB_LINE_BITS    = WB_ADDRESS_BITS - WB_OFFSET_BITS;
    localparam int WB_PTR_BITS     = log2(WB_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_buffer_if.sv
// Bundle of push, memory-write, lookup and flush signals between the cache
// controller / memory side (master) and the writeback buffer (slave).
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high (wb_valid/wb_ready for pushes, mem_write/mem_ready for
// memory writes). The source holds valid and its payload stable until that
// edge; ready may change freely and never depends on a future valid.
interface writeback_buffer_if
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int OFFSET_BITS  = WB_OFFSET_BITS,
    parameter int ADDRESS_BITS = WB_ADDRESS_BITS
);
    localparam int BLOCK_WIDTH = DATA_WIDTH << OFFSET_BITS;
    localparam int LINE_BITS   = ADDRESS_BITS - OFFSET_BITS;

    logic                    wb_valid;
    logic                    wb_ready;
    logic [LINE_BITS-1:0]    wb_line_addr;
    logic [BLOCK_WIDTH-1:0]  wb_data;
    logic                    mem_write;
    logic                    mem_ready;
    logic [ADDRESS_BITS-1:0] mem_address;
    logic [BLOCK_WIDTH-1:0]  mem_data;
    logic [LINE_BITS-1:0]    lookup_line_addr;
    logic                    lookup_hit;
    logic [BLOCK_WIDTH-1:0]  lookup_data;
    logic                    flush;
    logic                    flush_done;
    logic                    empty;
    wb_state_t               dbg_state;

    modport master (
        output wb_valid, wb_line_addr, wb_data, mem_ready, lookup_line_addr, flush,
        input  wb_ready, mem_write, mem_address, mem_data, lookup_hit, lookup_data,
               flush_done, empty, dbg_state
    );

    modport slave (
        input  wb_valid, wb_line_addr, wb_data, mem_ready, lookup_line_addr, flush,
        output wb_ready, mem_write, mem_address, mem_data, lookup_hit, lookup_data,
               flush_done, empty, dbg_state
    );

endinterface

// File: rtl/writeback_buffer_entry_match.sv
// Associative compare of the lookup address against every buffered line.
// With WB_FORWARD_EN defined it also reports which entry is the youngest
// match so the top can forward that block; otherwise only the hit is built.
module wb_entry_match
    import cache_pkg::*;
#(
    parameter int DEPTH     = WB_DEPTH,
    parameter int LINE_BITS = WB_LINE_BITS,
    parameter int PTR_BITS  = log2(DEPTH)
) (
    input  logic [LINE_BITS-1:0] entry_addr [DEPTH],
    input  logic [DEPTH-1:0]     valid_mask,
    input  logic [LINE_BITS-1:0] lookup_addr,
`ifdef WB_FORWARD_EN
    input  logic [PTR_BITS-1:0]  tail_ptr,
    output logic [PTR_BITS-1:0]  hit_idx,
`endif
    output logic                 hit
);

`ifdef WB_FORWARD_EN
    logic [PTR_BITS-1:0] slot;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last match wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        slot    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            slot = tail_ptr - PTR_BITS'(k);
            if (valid_mask[slot] && (entry_addr[slot] == lookup_addr)) begin
                hit     = 1'b1;
                hit_idx = slot;
            end
        end
    end
`else
    // Conflict detection only: any valid entry holding the line.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_mask[i] && (entry_addr[i] == lookup_addr)) hit = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/writeback_buffer.sv
// Dirty-victim writeback buffer: a DEPTH-entry FIFO of {line addr, block}
// drained to memory in order, with a lookup port so refills never read a
// stale line from memory. Optional macro WB_FORWARD_EN enables forwarding
// of the youngest matching block on lookup_data.
module writeback_buffer
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int OFFSET_BITS  = WB_OFFSET_BITS,
    parameter int ADDRESS_BITS = WB_ADDRESS_BITS,
    parameter int DEPTH        = WB_DEPTH
) (
    input logic              clock,
    input logic              reset,
    writeback_buffer_if.slave bus
);
    localparam int BLOCK_WIDTH = DATA_WIDTH << OFFSET_BITS;
    localparam int LINE_BITS   = ADDRESS_BITS - OFFSET_BITS;
    localparam int PTR_BITS    = log2(DEPTH);
    localparam int CNT_W       = PTR_BITS + 1;

    logic [LINE_BITS-1:0]   addr_q [DEPTH];
    logic [LINE_BITS-1:0]   addr_d [DEPTH];
    logic [BLOCK_WIDTH-1:0] data_q [DEPTH];
    logic [BLOCK_WIDTH-1:0] data_d [DEPTH];
    logic [PTR_BITS-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    wb_state_t              state_q, state_d;
    logic                   flush_pending_q, flush_pending_d;
    logic                   flush_done_q, flush_done_d;

    logic                   wb_ready;
    logic                   push, pop;
    logic [DEPTH-1:0]       valid_mask;
    logic [PTR_BITS-1:0]    rel;
    logic                   lookup_hit;

    // Accept/pop decisions; the full check uses the current count, no bypass.
    always_comb begin
        wb_ready = ~reset & (count_q != CNT_W'(DEPTH)) & ~flush_pending_q;
        push     = bus.wb_valid & wb_ready;
        pop      = (state_q == WRITE) & bus.mem_ready;
    end

    // Write the incoming victim line at the tail slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_d[i] = addr_q[i];
            data_d[i] = data_q[i];
        end
        if (push) begin
            addr_d[tail_q] = bus.wb_line_addr;
            data_d[tail_q] = bus.wb_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_BITS'(1);
        if (pop)  head_d = head_q + PTR_BITS'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Drain FSM next state plus flush tracking.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = WRITE;
            WRITE:   if (pop && (count_d == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A flush request while one is pending is absorbed; done clears it.
        flush_pending_d = flush_done_q ? 1'b0 : (flush_pending_q | bus.flush);
        flush_done_d    = flush_pending_d & (count_d == '0) & (state_d == IDLE);
    end

    // Drain FSM, pointers and flush state with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_done_d;
        end
    end

    // Entry storage; validity comes from head/count, so no reset is needed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
        end
    end

    // An entry is valid when its distance from head is below the count.
    always_comb begin
        valid_mask = '0;
        rel        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel           = PTR_BITS'(i) - head_q;
            valid_mask[i] = ({1'b0, rel} < count_q);
        end
    end

`ifdef WB_FORWARD_EN
    logic [PTR_BITS-1:0] hit_idx;

    wb_entry_match #(
        .DEPTH     (DEPTH),
        .LINE_BITS (LINE_BITS),
        .PTR_BITS  (PTR_BITS)
    ) u_match (
        .entry_addr  (addr_q),
        .valid_mask  (valid_mask),
        .lookup_addr (bus.lookup_line_addr),
        .tail_ptr    (tail_q),
        .hit_idx     (hit_idx),
        .hit         (lookup_hit)
    );

    assign bus.lookup_data = lookup_hit ? data_q[hit_idx] : '0;
`else
    wb_entry_match #(
        .DEPTH     (DEPTH),
        .LINE_BITS (LINE_BITS),
        .PTR_BITS  (PTR_BITS)
    ) u_match (
        .entry_addr  (addr_q),
        .valid_mask  (valid_mask),
        .lookup_addr (bus.lookup_line_addr),
        .hit         (lookup_hit)
    );

    assign bus.lookup_data = '0;
`endif

    assign bus.wb_ready    = wb_ready;
    assign bus.lookup_hit  = lookup_hit;
    assign bus.mem_write   = (state_q == WRITE);
    assign bus.mem_address = (state_q == WRITE) ? {addr_q[head_q], {OFFSET_BITS{1'b0}}} : '0;
    assign bus.mem_data    = (state_q == WRITE) ? data_q[head_q] : '0;
    assign bus.flush_done  = flush_done_q;
    assign bus.empty       = (count_q == '0);
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: a table of directed vectors, a
// few hand-written multi-cycle sequences and a randomized run, all checked
// against a queue-based reference model of the buffer's observable rules.
module tb_writeback_buffer;
    import cache_pkg::*;

    localparam int LB    = WB_LINE_BITS;
    localparam int BW    = WB_BLOCK_WIDTH;
    localparam int AW    = WB_ADDRESS_BITS;
    localparam int DEPTH = WB_DEPTH;
    localparam int W     = LB + BW;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    writeback_buffer_if bus ();

    writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model state ----------------
    // exp_q holds the buffered {line, block} pairs oldest first; memory must
    // see them in exactly this order.
    logic [W-1:0] exp_q[$];
    int           occ_prev;
    logic         m_pending;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Youngest buffered copy of a line.
    task automatic model_lookup(input logic [LB-1:0] a, output logic h, output logic [BW-1:0] d);
        h = 1'b0;
        d = '0;
        foreach (exp_q[i]) begin
            if (exp_q[i][W-1:BW] == a) begin
                h = 1'b1;
`ifdef WB_FORWARD_EN
                d = exp_q[i][BW-1:0];
`endif
            end
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Drives inputs just after a rising edge, checks every output against the
    // model, advances the model by the edge's effects, then waits the edge.
    task automatic cycle(input logic rst, input logic v, input logic [LB-1:0] la,
                         input logic [BW-1:0] d, input logic mr,
                         input logic [LB-1:0] lk, input logic fl);
        int             occ;
        logic           m_mw, m_fd, m_ready, m_hit;
        logic [BW-1:0]  m_ld, m_data;
        logic [AW-1:0]  m_addr;
        reset                = rst;
        bus.wb_valid         = v;
        bus.wb_line_addr     = la;
        bus.wb_data          = d;
        bus.mem_ready        = mr;
        bus.lookup_line_addr = lk;
        bus.flush            = fl;
        #1;
        occ = exp_q.size();
        // A line is presented once it has sat in the buffer for a full
        // cycle, and draining continues while the buffer stays occupied.
        m_mw    = (occ_prev > 0) && (occ > 0);
        m_fd    = m_pending && (occ == 0);
        m_ready = !rst && (occ < DEPTH) && !m_pending;
        m_addr  = '0;
        m_data  = '0;
        if (m_mw) begin
            m_addr = {exp_q[0][W-1:BW], {WB_OFFSET_BITS{1'b0}}};
            m_data = exp_q[0][BW-1:0];
        end
        model_lookup(lk, m_hit, m_ld);
        check("wb_ready",    160'(bus.wb_ready),    160'(m_ready));
        check("mem_write",   160'(bus.mem_write),   160'(m_mw));
        check("mem_address", 160'(bus.mem_address), 160'(m_addr));
        check("mem_data",    160'(bus.mem_data),    160'(m_data));
        check("empty",       160'(bus.empty),       160'(occ == 0));
        check("flush_done",  160'(bus.flush_done),  160'(m_fd));
        check("lookup_hit",  160'(bus.lookup_hit),  160'(m_hit));
        check("lookup_data", 160'(bus.lookup_data), 160'(m_ld));
        if (rst) begin
            exp_q.delete();
            m_pending = 1'b0;
            occ_prev  = 0;
        end else begin
            m_pending = m_fd ? 1'b0 : (m_pending | fl);
            if (m_mw && mr) void'(exp_q.pop_front());
            if (v && m_ready) exp_q.push_back({la, d});
            occ_prev = occ;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic mr);
        cycle(1'b0, 1'b0, '0, '0, mr, '0, 1'b0);
    endtask

    task automatic push(input logic [LB-1:0] la, input logic [BW-1:0] d, input logic mr);
        cycle(1'b0, 1'b1, la, d, mr, '0, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          v;
        logic [LB-1:0] la;
        logic [BW-1:0] d;
        logic          mr;
        logic          fl;
        logic          exp_ready;
        logic          exp_mw;
        logic [AW-1:0] exp_addr;
        logic          exp_empty;
        logic          exp_fd;
    } vec_t;

    vec_t vecs[6];

    localparam logic [BW-1:0] PAT_AA = {16{8'hAA}};
    localparam logic [BW-1:0] PAT_BB = {16{8'hBB}};
    localparam logic [BW-1:0] PAT_1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // ---------------- main test ----------------
    initial begin
        int pulses;
        int done_at;
        logic done_seen;
        logic [BW-1:0] exp_fwd;

        tests     = 0;
        fails     = 0;
        occ_prev  = 0;
        m_pending = 1'b0;

        // Single push of 0x123 with memory ready; then an empty flush.
        //            v     line           data    mr    fl    rdy   mw    addr          emp   fd
        vecs[0] = '{1'b1, 30'h0000123, PAT_1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[1] = '{1'b0, 30'h0,       '0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[2] = '{1'b0, 30'h0,       '0,    1'b1, 1'b0, 1'b1, 1'b1, 32'h0000048C, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 30'h0,       '0,    1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[4] = '{1'b0, 30'h0,       '0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[5] = '{1'b0, 30'h0,       '0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};

        // Reset: first edge brings flops out of X, second is model-checked.
        reset                = 1'b1;
        bus.wb_valid         = 1'b0;
        bus.wb_line_addr     = '0;
        bus.wb_data          = '0;
        bus.mem_ready        = 1'b0;
        bus.lookup_line_addr = '0;
        bus.flush            = 1'b0;
        @(posedge clock);
        #1;
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        check("rst_wb_ready",    160'(bus.wb_ready),    160'(0));
        check("rst_mem_write",   160'(bus.mem_write),   160'(0));
        check("rst_mem_address", 160'(bus.mem_address), 160'(0));
        check("rst_mem_data",    160'(bus.mem_data),    160'(0));
        check("rst_lookup_hit",  160'(bus.lookup_hit),  160'(0));
        check("rst_lookup_data", 160'(bus.lookup_data), 160'(0));
        check("rst_flush_done",  160'(bus.flush_done),  160'(0));
        check("rst_empty",       160'(bus.empty),       160'(1));
        idle(1'b0);

        for (int i = 0; i < 6; i++) begin
            check($sformatf("vec%0d_ready", i), 160'(bus.wb_ready),    160'(vecs[i].exp_ready));
            check($sformatf("vec%0d_mw", i),    160'(bus.mem_write),   160'(vecs[i].exp_mw));
            check($sformatf("vec%0d_addr", i),  160'(bus.mem_address), 160'(vecs[i].exp_addr));
            check($sformatf("vec%0d_empty", i), 160'(bus.empty),       160'(vecs[i].exp_empty));
            check($sformatf("vec%0d_fd", i),    160'(bus.flush_done),  160'(vecs[i].exp_fd));
            cycle(1'b0, vecs[i].v, vecs[i].la, vecs[i].d, vecs[i].mr, '0, vecs[i].fl);
        end

        // Fill to DEPTH with memory stalled, hold a 5th push, release one pop.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_ready", 160'(bus.wb_ready), 160'(1));
            push(LB'(32'h100 + i), {4{$urandom}}, 1'b0);
        end
        check("full_ready_low", 160'(bus.wb_ready), 160'(0));
        for (int i = 0; i < 2; i++) push(30'h104, PAT_1, 1'b0);
        check("held_ready_low", 160'(bus.wb_ready), 160'(0));
        push(30'h104, PAT_1, 1'b1);
        check("ready_after_pop", 160'(bus.wb_ready), 160'(1));
        push(30'h104, PAT_1, 1'b0);
        check("refull_ready_low", 160'(bus.wb_ready), 160'(0));
        for (int i = 0; i < DEPTH + 3; i++) idle(1'b1);
        check("fill_drained", 160'(bus.empty), 160'(1));

        // Duplicate lines: lookup returns the younger copy, memory sees both in order.
        cycle(1'b0, 1'b1, 30'h40, PAT_AA, 1'b0, 30'h40, 1'b0);
        cycle(1'b0, 1'b1, 30'h40, PAT_BB, 1'b0, 30'h40, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 30'h40, 1'b0);
`ifdef WB_FORWARD_EN
        exp_fwd = PAT_BB;
`else
        exp_fwd = '0;
`endif
        check("dup_hit",  160'(bus.lookup_hit),  160'(1));
        check("dup_data", 160'(bus.lookup_data), 160'(exp_fwd));
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 30'h41, 1'b0);
        check("dup_miss", 160'(bus.lookup_hit), 160'(0));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1, 30'h40, 1'b0);
        check("dup_gone", 160'(bus.lookup_hit), 160'(0));

        // Flush with three entries and memory ready toggling.
        for (int i = 0; i < 3; i++) push(LB'(32'h200 + i), {4{$urandom}}, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        pulses    = 0;
        done_seen = 1'b0;
        done_at   = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, !done_seen, 30'h300, PAT_1, i[0], '0, 1'b0);
            if (!done_seen) check("flush_ready_low", 160'(bus.wb_ready), 160'(0));
            if (bus.flush_done === 1'b1) begin
                pulses++;
                if (!done_seen) done_at = i;
                done_seen = 1'b1;
            end
            if (done_seen && (i >= done_at + 3)) break;
        end
        check("flush_pulses", 160'(pulses), 160'(1));
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Reset while writing with two entries buffered.
        push(30'h77, PAT_AA, 1'b0);
        push(30'h78, PAT_BB, 1'b0);
        check("pre_reset_mw", 160'(bus.mem_write), 160'(1));
        cycle(1'b1, 1'b0, '0, '0, 1'b1, 30'h77, 1'b0);
        check("post_reset_mw",    160'(bus.mem_write),  160'(0));
        check("post_reset_empty", 160'(bus.empty),      160'(1));
        check("post_reset_hit",   160'(bus.lookup_hit), 160'(0));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1, 30'h78, 1'b0);
            check("post_reset_no_write", 160'(bus.mem_write), 160'(0));
        end

        // Randomized traffic over a small line pool to create duplicates.
        for (int n = 0; n < 500; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 2) != 0),
                  LB'(32'h500 + $urandom_range(0, 5)),
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 1)),
                  LB'(32'h500 + $urandom_range(0, 7)),
                  ($urandom_range(0, 24) == 0));
        end
        for (int i = 0; i < DEPTH + 4; i++) idle(1'b1);
        check("final_empty", 160'(bus.empty), 160'(1));

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
# writeback_buffer

Dirty-victim writeback buffer between the L1 cache controller and the next memory level. When a port-0 miss evicts a dirty line (the victim tag, index and block come out of the cache memory the cycle after the read), the controller pushes the whole line here and immediately proceeds with the refill. The buffer drains entries to memory in FIFO order over a valid/ready write handshake. A lookup port lets refills see lines still waiting in the buffer, so memory is never read stale.

## Interface
- DATA_WIDTH, 32, bits per word
- OFFSET_BITS, 2, log2 words per line
- ADDRESS_BITS, 32, byte/word address width as used by the cache
- DEPTH, 4, buffer entries; power of two, ≥2
- Derived, not overridden:
  - BLOCK_WIDTH = DATA_WIDTH << OFFSET_BITS
  - LINE_BITS = ADDRESS_BITS - OFFSET_BITS
  - PTR_BITS = log2(DEPTH)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  push request from controller
- wb_ready  out  1  buffer can accept a push this cycle
- wb_line_addr  in  LINE_BITS  victim {tag, index}
- wb_data  in  BLOCK_WIDTH  victim block
- mem_write  out  1  head entry presented to memory
- mem_ready  in  1  memory accepts the presented write
- mem_address  out  ADDRESS_BITS  {head line addr, OFFSET_BITS zeros}
- mem_data  out  BLOCK_WIDTH  head block
- lookup_line_addr  in  LINE_BITS  refill address to check
- lookup_hit  out  1  a valid entry matches
- lookup_data  out  BLOCK_WIDTH  youngest matching block
- flush  in  1  single-cycle request: drain everything
- flush_done  out  1  one-cycle pulse when the flush completes
- empty  out  1  no valid entries

## Operation
- Storage: DEPTH entries of {line addr, block}, head/tail pointers, count in 0..DEPTH.
- Push: happens when wb_valid & wb_ready. The entry is written at the tail.
  - wb_ready = ~reset & (count != DEPTH) & ~flush_pending.
  - Pushing with wb_ready low is dropped. The controller must hold the request.
- Drain FSM:
  - IDLE → WRITE when count > 0.
  - In WRITE, mem_write=1 and mem_address/mem_data come from the head entry, held stable until mem_ready.
  - When mem_ready is high in WRITE, the head pops at that edge. The FSM stays in WRITE if count_next > 0, otherwise it returns to IDLE.
- Simultaneous push and pop: both happen and count is unchanged. A push is allowed at count=DEPTH only if… it is not: the full check uses the current count, with no bypass.
- Duplicate line addresses are allowed. FIFO drain guarantees memory ends with the youngest copy.
- Lookup (combinational on registered storage):
  - Scans valid entries for a match; youngest (nearest tail) wins.
  - An entry being pushed this cycle is not visible until the next cycle.
  - An entry being popped this cycle is still visible this cycle.
- Flush:
  - flush sets flush_pending.
  - When flush_pending & count=0 & state=IDLE, flush_done pulses for 1 cycle and flush_pending clears.
  - Flush while already empty gives flush_done on the next cycle.
  - A flush pulse while pending is ignored.
- Reset behaviour:
  - At the edge, all entries are discarded, pointers and count go to 0, FSM goes to IDLE, flush_pending clears.
  - Reset mid-WRITE abandons the write: mem_write is low from the reset edge onward.
- Output reset values: wb_ready 0 (while reset is high), mem_write 0, mem_address 0, mem_data 0, lookup_hit 0, lookup_data 0, flush_done 0, empty 1.
  - mem_address/mem_data are forced to 0 whenever mem_write=0.

## Timing
- Push-to-mem_write latency: 1 cycle minimum. Push at edge N, FSM enters WRITE at edge N+1, so mem_write is high in cycle N+1.
- Back-to-back drains with mem_ready held high: one entry per cycle, no bubble.
- lookup_hit/lookup_data: zero-cycle combinational from lookup_line_addr. The controller samples them in the same cycle it issues the refill.
- flush_done: registered, asserted the cycle after the last pop.

## Configuration
- WB_FORWARD_EN defined:
  - lookup_data returns the youngest matching block.
  - The controller may fill from it and skip the memory read.
- Undefined:
  - lookup_data is tied to 0 and the match mux is not built.
  - lookup_hit still reports address conflicts. The controller must stall its refill until lookup_hit deasserts (the entry has drained).

## Structure
- Shared package cache_pkg: log2 function, wb_state_t {IDLE, WRITE}, derived-width constants.
- One sub-module, wb_entry_match. It takes the entry addresses, valid mask, tail pointer and lookup address, and returns the hit plus the index of the youngest matching entry.

## Test plan
- Single push of line 0x0000123, memory ready held high:
  - mem_write is high exactly 1 cycle later, with mem_address 0x0000048C.
  - empty returns to 1 the cycle after.
- Four pushes with mem_ready=0:
  - wb_ready drops after the 4th push.
  - A 5th push is held.
  - One mem_ready pulse pops the head and wb_ready returns.
  - The held push is accepted and order is preserved.
- Two pushes to line 0x40 with data 0xAA… then 0xBB…:
  - lookup returns hit=1 and data 0xBB… (0 with WB_FORWARD_EN undefined).
  - Memory sees 0xAA… then 0xBB….
- Flush with 3 entries and mem_ready toggling 1/0:
  - wb_ready stays low until flush_done.
  - flush_done pulses once, the cycle after the 3rd pop.
- Reset asserted in WRITE with 2 entries:
  - mem_write is 0 after the edge, empty=1, lookup_hit=0.
  - No further memory writes occur.
